// File: rtl/nfm_pkg.sv
// Shared definitions for the nonlinear datapath back end: default widths,
// result collector state encodings and the derived beat count.
package nfm_pkg;

    localparam int DEF_FIX_POINT_WIDTH = 16;
    localparam int DEF_DATA_NUM        = 16;
    localparam int DEF_LANES           = 4;

    localparam logic [1:0] ST_COLLECT_ENC = 2'b01;
    localparam logic [1:0] ST_DRAIN_ENC   = 2'b10;

    typedef enum logic [1:0] {
        ST_COLLECT = ST_COLLECT_ENC,
        ST_DRAIN   = ST_DRAIN_ENC
    } collect_state_t;

    function automatic int beats_of(input int data_num, input int lanes);
        return data_num / lanes;
    endfunction

    localparam int DEF_BEATS = beats_of(DEF_DATA_NUM, DEF_LANES);

endpackage

// File: rtl/result_collector_if.sv
// Collector bus: controller result beats in, valid/ready result stream and
// status out. The collector uses the slave view, its environment the master view.
interface result_collector_if #(
    parameter int FIX_POINT_WIDTH = nfm_pkg::DEF_FIX_POINT_WIDTH,
    parameter int LANES           = nfm_pkg::DEF_LANES,
    parameter int DATA_NUM        = nfm_pkg::DEF_DATA_NUM
);
    localparam int IW = $clog2(DATA_NUM);

    logic                             valid;
    logic                             finish;
    logic [LANES*FIX_POINT_WIDTH-1:0] din;
    logic                             err_clr;
    logic [FIX_POINT_WIDTH-1:0]       dout;
    logic                             dout_valid;
    logic                             dout_ready;
    logic                             dout_last;
    logic [IW-1:0]                    dout_idx;
    logic                             busy;
    logic                             done;
    logic                             err_short;
    logic                             err_ovf;

    modport slave (
        input  valid, finish, din, err_clr, dout_ready,
        output dout, dout_valid, dout_last, dout_idx, busy, done, err_short, err_ovf
    );

    modport master (
        output valid, finish, din, err_clr, dout_ready,
        input  dout, dout_valid, dout_last, dout_idx, busy, done, err_short, err_ovf
    );

endinterface

// File: rtl/result_collector.sv
// Buffers one job of LANES-wide result beats and streams the results out one
// per valid/ready handshake, flagging short and overflowing jobs.
module result_collector #(
    parameter int FIX_POINT_WIDTH = nfm_pkg::DEF_FIX_POINT_WIDTH,
    parameter int DATA_NUM        = nfm_pkg::DEF_DATA_NUM,
    parameter int LANES           = nfm_pkg::DEF_LANES
) (
    input  logic               clk,
    input  logic               rst,
    result_collector_if.slave  bus
);
    import nfm_pkg::*;

    localparam int W     = FIX_POINT_WIDTH;
    localparam int BEATS = beats_of(DATA_NUM, LANES);
    localparam int CW    = $clog2(BEATS) + 1;
    localparam int IW    = $clog2(DATA_NUM);

    localparam logic [CW-1:0] BEATS_C  = CW'(BEATS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_ZERO = IW'(0);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_NUM - 1);

    collect_state_t state_q, state_d;
    logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
    logic [IW-1:0]  rd_idx_q, rd_idx_d;
    logic [W-1:0]   buf_q [DATA_NUM];

    logic [W-1:0]   dout_q;
    logic           dout_valid_q, dout_last_q, busy_q, done_q, err_short_q, err_ovf_q;
    logic [IW-1:0]  dout_idx_q;

    logic           accept_s, ovf_evt_s, short_evt_s, xfer_s, done_s, drain_s;
    logic [CW-1:0]  eff_cnt_s;
    logic [IW-1:0]  wr_base_s;
    logic [W-1:0]   rd_data_s;

    // Next-state logic for the collect/drain FSM and its counters.
    always_comb begin
        accept_s    = (state_q == ST_COLLECT) && bus.valid && (wr_cnt_q < BEATS_C);
        ovf_evt_s   = bus.valid && !accept_s;
        xfer_s      = (state_q == ST_DRAIN) && dout_valid_q && bus.dout_ready;
        eff_cnt_s   = accept_s ? (wr_cnt_q + CNT_ONE) : wr_cnt_q;
        wr_base_s   = IW'(32'(wr_cnt_q) * LANES);
        state_d     = state_q;
        wr_cnt_d    = eff_cnt_s;
        rd_idx_d    = rd_idx_q;
        short_evt_s = 1'b0;
        done_s      = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (bus.finish) begin
                    if (eff_cnt_s == BEATS_C) begin
                        state_d  = ST_DRAIN;
                        rd_idx_d = IDX_ZERO;
                    end else begin
                        short_evt_s = 1'b1;
                        wr_cnt_d    = CNT_ZERO;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_DRAIN: begin
                if (xfer_s && dout_last_q) begin
                    state_d  = ST_COLLECT;
                    wr_cnt_d = CNT_ZERO;
                    rd_idx_d = IDX_ZERO;
                    done_s   = 1'b1;
                end else if (xfer_s) begin
                    rd_idx_d = rd_idx_q + IDX_ONE;
                end else begin
                    rd_idx_d = rd_idx_q;
                end
            end
            default: begin
                state_d  = ST_COLLECT;
                wr_cnt_d = CNT_ZERO;
                rd_idx_d = IDX_ZERO;
            end
        endcase
    end

    // Data for the next stream output; with a single-beat job, result 0 is
    // being written in the very cycle the drain starts, so bypass it.
    always_comb begin
        drain_s = (state_d == ST_DRAIN);
        if (accept_s && (wr_cnt_q == CNT_ZERO) && (rd_idx_d == IDX_ZERO)) begin
            rd_data_s = bus.din[W-1:0];
        end else begin
            rd_data_s = buf_q[rd_idx_d];
        end
    end

    // Result buffer; contents are don't-care after reset so it has none.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int i = 0; i < LANES; i++) begin
                buf_q[wr_base_s + IW'(i)] <= bus.din[i*W +: W];
            end
        end
    end

    // FSM state, counters, registered stream outputs and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_COLLECT;
            wr_cnt_q     <= CNT_ZERO;
            rd_idx_q     <= IDX_ZERO;
            dout_q       <= {W{1'b0}};
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_idx_q   <= IDX_ZERO;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_short_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_idx_q     <= rd_idx_d;
            dout_q       <= drain_s ? rd_data_s : {W{1'b0}};
            dout_valid_q <= drain_s;
            dout_last_q  <= drain_s && (rd_idx_d == IDX_LAST);
            dout_idx_q   <= drain_s ? rd_idx_d : IDX_ZERO;
            busy_q       <= drain_s;
            done_q       <= done_s;
            // A set event in the same cycle as err_clr wins.
            err_short_q  <= short_evt_s ? 1'b1 : (bus.err_clr ? 1'b0 : err_short_q);
            err_ovf_q    <= ovf_evt_s   ? 1'b1 : (bus.err_clr ? 1'b0 : err_ovf_q);
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_last  = dout_last_q;
    assign bus.dout_idx   = dout_idx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err_short  = err_short_q;
    assign bus.err_ovf    = err_ovf_q;

endmodule

// File: tb/tb_result_collector.sv
// Scenario bench for result_collector: expected results are queued as beats
// are driven and compared against the stream as it drains.
module tb_result_collector;

    localparam int W  = 16;
    localparam int L  = 4;
    localparam int DN = 16;
    localparam int NB = DN / L;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_q[$];

    result_collector_if #(.FIX_POINT_WIDTH(W), .LANES(L), .DATA_NUM(DN)) bus ();

    result_collector #(.FIX_POINT_WIDTH(W), .DATA_NUM(DN), .LANES(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [L*W-1:0] make_beat(input int base, input int b);
        logic [L*W-1:0] r;
        for (int i = 0; i < L; i++) r[i*W +: W] = 16'(base + L*b + i);
        return r;
    endfunction

    task automatic send_beats(input int base, input int n, input bit fin_last);
        for (int b = 0; b < n; b++) begin
            bus.din    = make_beat(base, b);
            bus.valid  = 1'b1;
            bus.finish = fin_last && (b == n - 1);
            if (b < NB) begin
                for (int i = 0; i < L; i++) exp_q.push_back(base + L*b + i);
            end
            step();
        end
        bus.valid  = 1'b0;
        bus.finish = 1'b0;
    endtask

    task automatic pulse_finish();
        bus.finish = 1'b1;
        step();
        bus.finish = 1'b0;
    endtask

    task automatic drain(input int n, input bit alt, input bit chk_done, output int cyc);
        int got;
        int ev;
        bit rdy;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 200) begin
            rdy = alt ? (cyc % 2 == 1) : 1'b1;
            bus.dout_ready = rdy;
            if (bus.dout_valid) begin
                ev = (exp_q.size() > 0) ? exp_q[0] : -1;
                checks++;
                if (bus.dout !== 16'(ev)) begin
                    errors++;
                    $display("FAIL dout[%0d]: got %0d expected %0d", got, bus.dout, ev);
                end
                checks++;
                if (bus.dout_idx !== 4'(got)) begin
                    errors++;
                    $display("FAIL dout_idx: got %0d expected %0d", bus.dout_idx, got);
                end
                checks++;
                if (bus.dout_last !== (got == DN - 1)) begin
                    errors++;
                    $display("FAIL dout_last[%0d]: got %0b expected %0b", got, bus.dout_last, got == DN - 1);
                end
                if (rdy) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    got++;
                end
            end
            step();
            cyc++;
        end
        bus.dout_ready = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL drain_timeout: got %0d results expected %0d", got, n);
        end
        if (chk_done) begin
            checks++;
            if (bus.done !== 1'b1 || bus.dout_valid !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: done=%0b dout_valid=%0b expected 1/0", bus.done, bus.dout_valid);
            end
            step();
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL done_width: done=%0b busy=%0b expected 0/0", bus.done, bus.busy);
            end
        end
    endtask

    task automatic check_drain_start(input string name);
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_start: dout_valid=%0b busy=%0b expected 1/1", name, bus.dout_valid, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        step();
        step();
        checks++;
        if ({bus.dout_valid, bus.busy, bus.done, bus.err_short, bus.err_ovf, bus.dout_last} !== 6'b0
            || bus.dout !== 16'd0 || bus.dout_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: dout=%0d idx=%0d flags=%b expected all 0", bus.dout, bus.dout_idx,
                     {bus.dout_valid, bus.busy, bus.done, bus.err_short, bus.err_ovf, bus.dout_last});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_nominal();
        int cyc;
        send_beats(0, NB, 1'b0);
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL nominal_collect: dout_valid=%0b expected 0", bus.dout_valid);
        end
        pulse_finish();
        check_drain_start("nominal");
        drain(DN, 1'b0, 1'b1, cyc);
        checks++;
        if (cyc != DN) begin
            errors++;
            $display("FAIL nominal_latency: drain cycles %0d expected %0d", cyc, DN);
        end
        checks++;
        if (bus.err_short !== 1'b0 || bus.err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL nominal_flags: err_short=%0b err_ovf=%0b expected 0/0", bus.err_short, bus.err_ovf);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        send_beats(0, NB, 1'b0);
        pulse_finish();
        check_drain_start("bp");
        drain(DN, 1'b1, 1'b1, cyc);
        checks++;
        if (cyc != 2*DN) begin
            errors++;
            $display("FAIL bp_latency: drain cycles %0d expected %0d", cyc, 2*DN);
        end
    endtask

    task automatic test_short_job();
        int cyc;
        bit seen;
        send_beats(0, NB - 1, 1'b0);
        exp_q.delete();
        pulse_finish();
        seen = bus.dout_valid;
        for (int k = 0; k < 4; k++) begin
            step();
            seen = seen | bus.dout_valid;
        end
        checks++;
        if (bus.err_short !== 1'b1 || seen) begin
            errors++;
            $display("FAIL short_job: err_short=%0b valid_seen=%0b expected 1/0", bus.err_short, seen);
        end
        send_beats(100, NB, 1'b0);
        pulse_finish();
        check_drain_start("short_next");
        drain(DN, 1'b0, 1'b1, cyc);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err_short !== 1'b0) begin
            errors++;
            $display("FAIL short_clear: err_short=%0b expected 0", bus.err_short);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        send_beats(0, NB + 1, 1'b0);
        checks++;
        if (bus.err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: err_ovf=%0b expected 1", bus.err_ovf);
        end
        pulse_finish();
        check_drain_start("ovf");
        drain(DN, 1'b0, 1'b1, cyc);
        checks++;
        if (exp_q.size() != 0 || bus.dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_extra: queue=%0d dout_valid=%0b expected 0/0", exp_q.size(), bus.dout_valid);
        end
    endtask

    task automatic test_finish_same_cycle();
        int cyc;
        send_beats(200, NB, 1'b1);
        check_drain_start("same_cycle");
        drain(DN, 1'b0, 1'b1, cyc);
    endtask

    task automatic test_err_clr();
        int cyc;
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: err_ovf=%0b expected 0", bus.err_ovf);
        end
        send_beats(400, NB, 1'b0);
        bus.din     = make_beat(900, 0);
        bus.valid   = 1'b1;
        bus.err_clr = 1'b1;
        step();
        bus.valid   = 1'b0;
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL err_clr_set_wins: err_ovf=%0b expected 1", bus.err_ovf);
        end
        pulse_finish();
        drain(DN, 1'b0, 1'b1, cyc);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        int cyc;
        send_beats(50, NB, 1'b0);
        pulse_finish();
        drain(5, 1'b0, 1'b0, cyc);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dout !== 16'd0 || bus.dout_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_async: dout_valid=%0b busy=%0b dout=%0d idx=%0d expected 0", bus.dout_valid,
                     bus.busy, bus.dout, bus.dout_idx);
        end
        #1 rst = 1'b1;
        exp_q.delete();
        step();
        send_beats(300, NB, 1'b0);
        pulse_finish();
        check_drain_start("after_reset");
        drain(DN, 1'b0, 1'b1, cyc);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        bus.valid      = 1'b0;
        bus.finish     = 1'b0;
        bus.din        = '0;
        bus.err_clr    = 1'b0;
        bus.dout_ready = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_short_job();
        test_overflow();
        test_finish_same_cycle();
        test_err_clr();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
